rgb_led_scheduler: RTL

- Shares the board's single RGB LED between three status requesters (heartbeat, status, error) by fixed priority with a minimum-visible hold time.
- Generates solid or blink output for the granted requester from a millisecond-scale tick prescaler.
- Sits between the design's status sources and the RGB LED driver/pad logic in top.

---
 rtl/rgb_led_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rgb_led_scheduler.sv
// Fixed-priority owner selection for the shared RGB LED, with a minimum hold
// time per grant and tick-driven solid/blink output for the current owner.
module rgb_led_scheduler #(
  parameter int TICK_DIV         = 12000,
  parameter int MIN_HOLD_TICKS   = 250,
  parameter int BLINK_HALF_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] req_mode,
  input  logic [8:0] req_color,
  output logic [2:0] grant,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       tick
);

  localparam int PRESC_W = $clog2(TICK_DIV + 1);
  localparam int HOLD_W  = $clog2(MIN_HOLD_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(MIN_HOLD_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_OWN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          led_q, led_d;

  logic                tick_int;
  logic                enter_hold;
  logic [2:0]          new_grant;
  logic [2:0]          higher_mask;
  logic [2:0]          owner_color;
  logic                owner_blink;

  function automatic logic [2:0] highest_req(input logic [2:0] r);
    logic [2:0] g;
    g = 3'b000;
    if (r[2])      g = 3'b100;
    else if (r[1]) g = 3'b010;
    else if (r[0]) g = 3'b001;
    return g;
  endfunction

  // Free-running prescaler; arbitration never disturbs it.
  always_comb begin
    tick_int = (presc_q == PRESC_LAST);
    presc_d  = tick_int ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    higher_mask = 3'b000;
    case (grant_q)
      3'b001:  higher_mask = 3'b110;
      3'b010:  higher_mask = 3'b100;
      default: higher_mask = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    enter_hold  = 1'b0;
    new_grant   = highest_req(req);

    case (state_q)
      S_IDLE: begin
        if (|req) enter_hold = 1'b1;
      end
      S_HOLD: begin
        if (tick_int) begin
          if (hold_q <= HOLD_ONE) begin
            state_d = S_OWN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      S_OWN: begin
        // A higher request wins even if the owner dropped in the same cycle.
        if (|(req & higher_mask)) begin
          enter_hold = 1'b1;
        end else if (!(|(req & grant_q))) begin
          if (|req) begin
            enter_hold = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = 3'b000;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
      end
    endcase

    if ((state_q == S_HOLD || state_q == S_OWN) && tick_int) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Fresh loads override any tick seen in the transition cycle.
    if (enter_hold) begin
      state_d     = S_HOLD;
      grant_d     = new_grant;
      hold_d      = HOLD_LOAD;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end
  end

  // Colour and mode are taken live from whoever owns the LED next cycle.
  always_comb begin
    owner_color = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (grant_d[i]) owner_color = req_color[3*i +: 3];
    end
    owner_blink = |(grant_d & req_mode);
    led_d       = ((grant_d != 3'b000) && (!owner_blink || phase_d)) ? owner_color : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      grant_q     <= 3'b000;
      led_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      grant_q     <= grant_d;
      led_q       <= led_d;
    end
  end

  assign grant = grant_q;
  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];
  assign tick  = tick_int;

endmodule
